// File: rtl/ir_tx_pkg.sv
// Shared state encoding, default Gree-style frame timing and width helpers
// for the IR frame transmitter.
package ir_tx_pkg;

   typedef enum logic [3:0] {
      IDLE,
      HDR_MARK,
      HDR_SPACE,
      S0_MARK,
      S0_SPACE,
      CONN_MARK,
      CONN_SPACE,
      S1_MARK,
      S1_SPACE,
      STOP_MARK,
      GUARD,
      DONE
   } state_t;

   // 50 MHz clock: 20 us tick, ~38 kHz carrier
   localparam int DEF_TICK_CYC     = 1000;
   localparam int DEF_CARRIER_HALF = 658;

   localparam int DEF_SEG0_W       = 35;
   localparam int DEF_SEG1_W       = 32;
   localparam int DEF_HDR_MARK_T   = 450;
   localparam int DEF_HDR_SPACE_T  = 225;
   localparam int DEF_BIT_MARK_T   = 28;
   localparam int DEF_ZERO_SPACE_T = 28;
   localparam int DEF_ONE_SPACE_T  = 84;
   localparam int DEF_CONN_SPACE_T = 1000;
   localparam int DEF_GUARD_T      = 2000;

   localparam int BIT_IDX_W = $clog2(64) + 1;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic is_mark(input state_t s);
      return (s == HDR_MARK) || (s == S0_MARK) || (s == CONN_MARK) ||
             (s == S1_MARK)  || (s == STOP_MARK);
   endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Carrier square wave: level toggles every CARRIER_HALF cycles; sync_restart
// forces phase 0 / level high so the next cycle starts a full high half-period.
module ir_carrier_gen
   import ir_tx_pkg::*;
#(
   parameter int CARRIER_HALF = DEF_CARRIER_HALF
)(
   input  logic clk,
   input  logic rst,
   input  logic sync_restart,
   output logic carrier
);

   localparam int PW = $clog2(CARRIER_HALF) + 1;

   logic [PW-1:0] phase;
   logic          wrap;

   assign wrap = (phase == PW'(CARRIER_HALF - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         phase   <= '0;
         carrier <= 1'b0;
      end else if (sync_restart) begin
         phase   <= '0;
         carrier <= 1'b1;
      end else if (wrap) begin
         phase   <= '0;
         carrier <= ~carrier;
      end else begin
         phase   <= phase + 1'b1;
      end
   end

endmodule

// File: rtl/ir_frame_tx.sv
// Pulse-distance IR frame sender: header, segment 0, optional connector and segment 1, stop, guard.
// Outputs are registered from the current state, so they trail the state register by one cycle.
module ir_frame_tx
   import ir_tx_pkg::*;
#(
   parameter int TICK_CYC     = DEF_TICK_CYC,
   parameter int CARRIER_HALF = DEF_CARRIER_HALF,
   parameter int SEG0_W       = DEF_SEG0_W,
   parameter int SEG1_W       = DEF_SEG1_W,
   parameter int HDR_MARK_T   = DEF_HDR_MARK_T,
   parameter int HDR_SPACE_T  = DEF_HDR_SPACE_T,
   parameter int BIT_MARK_T   = DEF_BIT_MARK_T,
   parameter int ZERO_SPACE_T = DEF_ZERO_SPACE_T,
   parameter int ONE_SPACE_T  = DEF_ONE_SPACE_T,
   parameter int CONN_SPACE_T = DEF_CONN_SPACE_T,
   parameter int GUARD_T      = DEF_GUARD_T,
   parameter int CARRIER_EN   = 1,
   parameter int OUT_INV      = 0,
   localparam int S1W         = (SEG1_W > 0) ? SEG1_W : 1
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [SEG0_W-1:0] seg0_data,
   input  logic [S1W-1:0]    seg1_data,
   output logic              ir_out,
   output logic              ir_env,
   output logic              busy,
   output logic              done,
   output logic              led_out
);

   localparam int MAX_T = max2(max2(max2(HDR_MARK_T, HDR_SPACE_T), max2(BIT_MARK_T, ZERO_SPACE_T)),
                               max2(max2(ONE_SPACE_T, CONN_SPACE_T), GUARD_T));
   localparam int CW = $clog2(TICK_CYC) + 1;
   localparam int TW = $clog2(MAX_T) + 1;

   state_t                 state, state_nxt;
   logic [CW-1:0]          cyc_cnt;
   logic [TW-1:0]          tick_cnt;
   logic [BIT_IDX_W-1:0]   bit_idx;
   logic [SEG0_W-1:0]      sh0;
   logic [S1W-1:0]         sh1;
   logic                   bit0_val, bit1_val;
   logic                   tick_end, state_end;
   logic                   accept, sync_restart, carrier, env_now;
   int                     dur;

   assign bit0_val     = |(sh0 & (SEG0_W'(1) << bit_idx));
   assign bit1_val     = |(sh1 & (S1W'(1) << bit_idx));
   // done is high in the first IDLE cycle, which keeps start ignored there
   assign accept       = (state == IDLE) && start && !done;
   assign env_now      = is_mark(state);
   assign sync_restart = (state_nxt != state) && is_mark(state_nxt);
   assign tick_end     = (cyc_cnt == CW'(TICK_CYC - 1));
   assign state_end    = tick_end && (tick_cnt == TW'(dur - 1));
   assign led_out      = busy;

   always_comb begin
      dur = 1;
      case (state)
         HDR_MARK:                               dur = HDR_MARK_T;
         HDR_SPACE:                              dur = HDR_SPACE_T;
         S0_MARK, CONN_MARK, S1_MARK, STOP_MARK: dur = BIT_MARK_T;
         S0_SPACE:                               dur = bit0_val ? ONE_SPACE_T : ZERO_SPACE_T;
         S1_SPACE:                               dur = bit1_val ? ONE_SPACE_T : ZERO_SPACE_T;
         CONN_SPACE:                             dur = CONN_SPACE_T;
         GUARD:                                  dur = GUARD_T;
         default:                                dur = 1;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = HDR_MARK;
         DONE: state_nxt = IDLE;
         default: begin
            if (state_end) begin
               case (state)
                  HDR_MARK:   state_nxt = HDR_SPACE;
                  HDR_SPACE:  state_nxt = S0_MARK;
                  S0_MARK:    state_nxt = S0_SPACE;
                  S0_SPACE: begin
                     if (bit_idx != BIT_IDX_W'(SEG0_W - 1)) state_nxt = S0_MARK;
                     else if (SEG1_W > 0)                  state_nxt = CONN_MARK;
                     else                                  state_nxt = STOP_MARK;
                  end
                  CONN_MARK:  state_nxt = CONN_SPACE;
                  CONN_SPACE: state_nxt = S1_MARK;
                  S1_MARK:    state_nxt = S1_SPACE;
                  S1_SPACE: begin
                     if (bit_idx != BIT_IDX_W'(SEG1_W - 1)) state_nxt = S1_MARK;
                     else                                   state_nxt = STOP_MARK;
                  end
                  STOP_MARK:  state_nxt = GUARD;
                  GUARD:      state_nxt = DONE;
                  default:    state_nxt = IDLE;
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cyc_cnt  <= '0;
         tick_cnt <= '0;
         bit_idx  <= '0;
         sh0      <= '0;
         sh1      <= '0;
         ir_env   <= 1'b0;
         ir_out   <= (OUT_INV != 0);
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state <= state_nxt;

         if ((state_nxt != state) || (state == IDLE)) begin
            cyc_cnt  <= '0;
            tick_cnt <= '0;
         end else if (tick_end) begin
            cyc_cnt  <= '0;
            tick_cnt <= tick_cnt + 1'b1;
         end else begin
            cyc_cnt  <= cyc_cnt + 1'b1;
         end

         if (accept) begin
            sh0 <= seg0_data;
            sh1 <= seg1_data;
         end

         if (state_nxt != state) begin
            case (state)
               IDLE, HDR_SPACE, CONN_SPACE: bit_idx <= '0;
               S0_SPACE, S1_SPACE:          bit_idx <= bit_idx + 1'b1;
               default:                     bit_idx <= bit_idx;
            endcase
         end

         ir_env <= env_now;
         ir_out <= ((CARRIER_EN != 0) ? (env_now & carrier) : env_now) ^ (OUT_INV != 0);
         busy   <= (state != IDLE);
         done   <= (state == DONE);
      end
   end

   ir_carrier_gen #(
      .CARRIER_HALF (CARRIER_HALF)
   ) u_carrier (
      .clk          (clk),
      .rst          (rst),
      .sync_restart (sync_restart),
      .carrier      (carrier)
   );

endmodule
